// File: rtl/vga_vram_arbiter_if.sv
// Bus bundle for vga_vram_arbiter: fetch trigger, host write port, RAM port,
// line-buffer port and status pulses. The arbiter uses the slave modport; the
// surrounding system (timing generator, host, RAM) uses the master modport.
interface vga_vram_arbiter_if #(
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int LB_AW  = 5
);
   logic              i_fetch_req;
   logic [4:0]        i_fetch_row;
   logic              i_wr_valid;
   logic              o_wr_ready;
   logic [ADDR_W-1:0] i_wr_addr;
   logic [DATA_W-1:0] i_wr_data;
   logic              o_wr_err;
   logic              o_ram_en;
   logic              o_ram_we;
   logic [ADDR_W-1:0] o_ram_addr;
   logic [DATA_W-1:0] o_ram_wdata;
   logic [DATA_W-1:0] i_ram_rdata;
   logic              o_lb_we;
   logic [LB_AW-1:0]  o_lb_addr;
   logic [DATA_W-1:0] o_lb_data;
   logic              o_fetch_done;
   logic              o_overrun;

   modport slave (
      input  i_fetch_req, i_fetch_row, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
      output o_wr_ready, o_wr_err, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
             o_lb_we, o_lb_addr, o_lb_data, o_fetch_done, o_overrun
   );

   modport master (
      output i_fetch_req, i_fetch_row, i_wr_valid, i_wr_addr, i_wr_data, i_ram_rdata,
      input  o_wr_ready, o_wr_err, o_ram_en, o_ram_we, o_ram_addr, o_ram_wdata,
             o_lb_we, o_lb_addr, o_lb_data, o_fetch_done, o_overrun
   );
endinterface

// File: rtl/vga_vram_arbiter.sv
// Cell-RAM arbiter between the scan-out row fetch (absolute priority, copies
// one text row into the line buffer during hblank) and the host write port.
// Optional feature: define VGA_VRAM_WR_SKID_EN to add a one-entry host write
// skid register so writes can be accepted while a fetch is in progress.
module vga_vram_arbiter #(
   parameter int COLS   = 25,
   parameter int ROWS   = 18,
   parameter int ADDR_W = 9,
   parameter int DATA_W = 8,
   parameter int LB_AW  = 5
) (
   input logic               i_clk,
   input logic               i_rst_n,
   vga_vram_arbiter_if.slave bus
);

   localparam logic [LB_AW-1:0] COL_LAST = LB_AW'(COLS - 1);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

   state_t            state, state_nx;
   logic [ADDR_W-1:0] base_q, base_nx;
   logic [LB_AW-1:0]  col_q, col_nx;
   logic              drain_q, drain_nx;

   logic              ram_en_q, ram_en_nx;
   logic              ram_we_q, ram_we_nx;
   logic [ADDR_W-1:0] ram_addr_q, ram_addr_nx;
   logic [DATA_W-1:0] ram_wdata_q, ram_wdata_nx;
   logic              wr_err_q, wr_err_nx;
   logic              overrun_q, overrun_nx;

   logic              rd_pend_q;
   logic [LB_AW-1:0]  rd_col_q;
   logic              lb_we_q;
   logic [LB_AW-1:0]  lb_addr_q;
   logic [DATA_W-1:0] lb_data_q;

   logic              ready_c;
   logic              row_bad;
   logic              host_bad;
   logic [ADDR_W-1:0] fetch_base;

`ifdef VGA_VRAM_WR_SKID_EN
   logic              skid_valid_q, skid_valid_nx;
   logic [ADDR_W-1:0] skid_addr_q, skid_addr_nx;
   logic [DATA_W-1:0] skid_data_q, skid_data_nx;
   logic              skid_bad;

   assign skid_bad = 32'(skid_addr_q) >= 32'(COLS * ROWS);
`endif

   assign row_bad    = 32'(bus.i_fetch_row) >= 32'(ROWS);
   assign host_bad   = 32'(bus.i_wr_addr) >= 32'(COLS * ROWS);
   assign fetch_base = ADDR_W'(32'(bus.i_fetch_row) * 32'(COLS));

   // State register and registered RAM/status outputs
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         base_q       <= '0;
         col_q        <= '0;
         drain_q      <= '0;
         ram_en_q     <= '0;
         ram_we_q     <= '0;
         ram_addr_q   <= '0;
         ram_wdata_q  <= '0;
         wr_err_q     <= '0;
         overrun_q    <= '0;
`ifdef VGA_VRAM_WR_SKID_EN
         skid_valid_q <= '0;
         skid_addr_q  <= '0;
         skid_data_q  <= '0;
`endif
      end else begin
         state        <= state_nx;
         base_q       <= base_nx;
         col_q        <= col_nx;
         drain_q      <= drain_nx;
         ram_en_q     <= ram_en_nx;
         ram_we_q     <= ram_we_nx;
         ram_addr_q   <= ram_addr_nx;
         ram_wdata_q  <= ram_wdata_nx;
         wr_err_q     <= wr_err_nx;
         overrun_q    <= overrun_nx;
`ifdef VGA_VRAM_WR_SKID_EN
         skid_valid_q <= skid_valid_nx;
         skid_addr_q  <= skid_addr_nx;
         skid_data_q  <= skid_data_nx;
`endif
      end
   end

   // Next-state, arbitration and next RAM command
   always_comb begin
      state_nx     = state;
      base_nx      = base_q;
      col_nx       = col_q;
      drain_nx     = drain_q;
      ram_en_nx    = 1'b0;
      ram_we_nx    = 1'b0;
      ram_addr_nx  = ram_addr_q;
      ram_wdata_nx = ram_wdata_q;
      wr_err_nx    = 1'b0;
      overrun_nx   = bus.i_fetch_req & (state != IDLE);
      ready_c      = 1'b0;
`ifdef VGA_VRAM_WR_SKID_EN
      skid_valid_nx = skid_valid_q;
      skid_addr_nx  = skid_addr_q;
      skid_data_nx  = skid_data_q;
`endif

      unique case (state)
         IDLE: begin
            col_nx   = '0;
            drain_nx = 1'b0;
`ifdef VGA_VRAM_WR_SKID_EN
            ready_c  = ~bus.i_fetch_req & ~skid_valid_q;
`else
            ready_c  = ~bus.i_fetch_req;
`endif
            if (bus.i_fetch_req) begin
               base_nx = fetch_base;
               if (row_bad) begin
                  state_nx = DONE;
               end else begin
                  state_nx    = FETCH;
                  ram_en_nx   = 1'b1;
                  ram_addr_nx = fetch_base;
               end
`ifdef VGA_VRAM_WR_SKID_EN
            // A parked write drains before any new host write is taken
            end else if (skid_valid_q) begin
               skid_valid_nx = 1'b0;
               if (skid_bad) begin
                  wr_err_nx = 1'b1;
               end else begin
                  ram_en_nx    = 1'b1;
                  ram_we_nx    = 1'b1;
                  ram_addr_nx  = skid_addr_q;
                  ram_wdata_nx = skid_data_q;
               end
`endif
            end else if (bus.i_wr_valid) begin
               if (host_bad) begin
                  wr_err_nx = 1'b1;
               end else begin
                  ram_en_nx    = 1'b1;
                  ram_we_nx    = 1'b1;
                  ram_addr_nx  = bus.i_wr_addr;
                  ram_wdata_nx = bus.i_wr_data;
               end
            end
         end
         FETCH: begin
            // col_q is the column whose read is on the RAM port this cycle
            if (col_q == COL_LAST) begin
               state_nx = DRAIN;
            end else begin
               col_nx      = col_q + LB_AW'(1);
               ram_en_nx   = 1'b1;
               ram_addr_nx = base_q + ADDR_W'(col_q) + ADDR_W'(1);
            end
         end
         DRAIN: begin
            if (drain_q) state_nx = DONE;
            else         drain_nx = 1'b1;
         end
         DONE: begin
            state_nx = IDLE;
         end
      endcase

`ifdef VGA_VRAM_WR_SKID_EN
      if (state != IDLE) begin
         ready_c = ~skid_valid_q;
         if (bus.i_wr_valid && !skid_valid_q) begin
            skid_valid_nx = 1'b1;
            skid_addr_nx  = bus.i_wr_addr;
            skid_data_nx  = bus.i_wr_data;
         end
      end
`endif
   end

   // Read return pipeline: RAM data arrives one cycle after the strobe and
   // is registered into the line buffer the cycle after that
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         rd_pend_q <= '0;
         rd_col_q  <= '0;
         lb_we_q   <= '0;
         lb_addr_q <= '0;
         lb_data_q <= '0;
      end else begin
         rd_pend_q <= ram_en_q & ~ram_we_q;
         rd_col_q  <= col_q;
         lb_we_q   <= rd_pend_q;
         if (rd_pend_q) begin
            lb_addr_q <= rd_col_q;
            lb_data_q <= bus.i_ram_rdata;
         end
      end
   end

   assign bus.o_wr_ready   = ready_c & i_rst_n;
   assign bus.o_wr_err     = wr_err_q;
   assign bus.o_ram_en     = ram_en_q;
   assign bus.o_ram_we     = ram_we_q;
   assign bus.o_ram_addr   = ram_addr_q;
   assign bus.o_ram_wdata  = ram_wdata_q;
   assign bus.o_lb_we      = lb_we_q;
   assign bus.o_lb_addr    = lb_addr_q;
   assign bus.o_lb_data    = lb_data_q;
   assign bus.o_fetch_done = (state == DONE);
   assign bus.o_overrun    = overrun_q;

endmodule

// File: tb/tb_vga_vram_arbiter.sv
// Self-checking bench for vga_vram_arbiter: randomized host writes and row
// fetches, checked against a reference cell memory and cycle-level event logs.
module tb_vga_vram_arbiter;
   localparam int COLS   = 25;
   localparam int ROWS   = 18;
   localparam int ADDR_W = 9;
   localparam int DATA_W = 8;
   localparam int LB_AW  = 5;
   localparam int CELLS  = COLS * ROWS;

   typedef struct {
      int c;
      int a;
      int d;
   } ev_t;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   cyc   = 0;
   int   n_checks = 0;
   int   n_fail   = 0;

   logic [7:0] mem       [0:511];
   logic [7:0] model_mem [0:511];

   ev_t rd_q[$];
   ev_t wr_q[$];
   ev_t lb_q[$];
   int  done_q[$];
   int  ovr_q[$];
   int  err_q[$];

   vga_vram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .LB_AW(LB_AW)) bus ();

   vga_vram_arbiter #(
      .COLS(COLS), .ROWS(ROWS), .ADDR_W(ADDR_W), .DATA_W(DATA_W), .LB_AW(LB_AW)
   ) dut (
      .i_clk(clk),
      .i_rst_n(rst_n),
      .bus(bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Single-port RAM model: read data valid the cycle after the strobe
   always @(posedge clk) begin
      if (bus.o_ram_en) begin
         if (bus.o_ram_we) mem[bus.o_ram_addr] = bus.o_ram_wdata;
         else              bus.i_ram_rdata <= mem[bus.o_ram_addr];
      end
   end

   // Event logger, sampled mid-cycle
   always @(negedge clk) begin
      if (bus.o_ram_en && !bus.o_ram_we) rd_q.push_back('{cyc, int'(bus.o_ram_addr), 0});
      if (bus.o_ram_en && bus.o_ram_we)
         wr_q.push_back('{cyc, int'(bus.o_ram_addr), int'(bus.o_ram_wdata)});
      if (bus.o_lb_we) lb_q.push_back('{cyc, int'(bus.o_lb_addr), int'(bus.o_lb_data)});
      if (bus.o_fetch_done) done_q.push_back(cyc);
      if (bus.o_overrun)    ovr_q.push_back(cyc);
      if (bus.o_wr_err)     err_q.push_back(cyc);
   end

   task automatic clear_logs();
      rd_q.delete(); wr_q.delete(); lb_q.delete();
      done_q.delete(); ovr_q.delete(); err_q.delete();
   endtask

   task automatic test_reset();
      logic [36:0] outs;
      bus.i_wr_valid = 1'b1;
      bus.i_wr_addr  = 9'h012;
      bus.i_wr_data  = 8'h5A;
      repeat (2) @(posedge clk);
      #1;
      outs = {bus.o_wr_ready, bus.o_wr_err, bus.o_ram_en, bus.o_ram_we, bus.o_ram_addr,
              bus.o_ram_wdata, bus.o_lb_we, bus.o_lb_addr, bus.o_lb_data,
              bus.o_fetch_done, bus.o_overrun};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %h expected 0", outs);
      end
      bus.i_wr_valid = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (2) @(posedge clk);
   endtask

   task automatic test_write(input int count);
      int a, d;
      bit bad;
      for (int i = 0; i < count; i++) begin
         if (i == 0)      begin a = 'h012; d = 'hA5; end
         else if (i == 1) begin a = 450;   d = 'h3C; end
         else             begin a = int'($urandom_range(0, 511)); d = int'($urandom_range(0, 255)); end
         bad = (a >= CELLS);
         @(posedge clk); #1;
         bus.i_wr_valid = 1'b1;
         bus.i_wr_addr  = ADDR_W'(a);
         bus.i_wr_data  = DATA_W'(d);
         @(negedge clk);
         n_checks++;
         if (bus.o_wr_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL write_ready: got %b expected 1", bus.o_wr_ready);
         end
         @(posedge clk); #1;
         bus.i_wr_valid = 1'b0;
         @(negedge clk);
         n_checks++;
         if (bus.o_ram_en !== !bad || bus.o_wr_err !== bad) begin
            n_fail++;
            $display("FAIL write_strobe addr=%0d: got en=%b err=%b expected en=%b err=%b",
                     a, bus.o_ram_en, bus.o_wr_err, !bad, bad);
         end
         if (!bad) begin
            n_checks++;
            if (bus.o_ram_we !== 1'b1 || int'(bus.o_ram_addr) != a || int'(bus.o_ram_wdata) != d) begin
               n_fail++;
               $display("FAIL write_cmd: got we=%b addr=%0d data=%0d expected we=1 addr=%0d data=%0d",
                        bus.o_ram_we, bus.o_ram_addr, bus.o_ram_wdata, a, d);
            end
            model_mem[a] = 8'(d);
         end
         @(negedge clk);
         n_checks++;
         if (bus.o_ram_en !== 1'b0 || bus.o_wr_err !== 1'b0) begin
            n_fail++;
            $display("FAIL write_one_cycle: got en=%b err=%b expected 0 0", bus.o_ram_en, bus.o_wr_err);
         end
      end
   endtask

   // Fetch one row; optionally pulse a second request ovr_at cycles in
   task automatic test_fetch(input int row, input int ovr_at);
      int t0;
      clear_logs();
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b1;
      bus.i_fetch_row = 5'(row);
      t0 = cyc;
      for (int c = 1; c < 34; c++) begin
         @(posedge clk); #1;
         bus.i_fetch_req = (c == ovr_at);
         bus.i_fetch_row = 5'($urandom_range(0, 31));
      end
      bus.i_fetch_req = 1'b0;
      n_checks++;
      if (rd_q.size() != COLS) begin
         n_fail++;
         $display("FAIL fetch_read_count row=%0d: got %0d expected %0d", row, rd_q.size(), COLS);
      end
      for (int k = 0; k < COLS && k < rd_q.size(); k++) begin
         n_checks++;
         if (rd_q[k].c != t0 + 1 + k || rd_q[k].a != row * COLS + k) begin
            n_fail++;
            $display("FAIL fetch_read k=%0d: got cyc=%0d addr=%0d expected cyc=%0d addr=%0d",
                     k, rd_q[k].c - t0, rd_q[k].a, 1 + k, row * COLS + k);
         end
      end
      n_checks++;
      if (lb_q.size() != COLS) begin
         n_fail++;
         $display("FAIL fetch_lb_count row=%0d: got %0d expected %0d", row, lb_q.size(), COLS);
      end
      for (int k = 0; k < COLS && k < lb_q.size(); k++) begin
         n_checks++;
         if (lb_q[k].c != t0 + 3 + k || lb_q[k].a != k || lb_q[k].d != int'(model_mem[row * COLS + k])) begin
            n_fail++;
            $display("FAIL fetch_lb k=%0d: got cyc=%0d addr=%0d data=%0d expected cyc=%0d addr=%0d data=%0d",
                     k, lb_q[k].c - t0, lb_q[k].a, lb_q[k].d, 3 + k, k, model_mem[row * COLS + k]);
         end
      end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != t0 + COLS + 3) begin
         n_fail++;
         $display("FAIL fetch_done: got count=%0d first=%0d expected count=1 cyc=%0d",
                  done_q.size(), (done_q.size() > 0) ? done_q[0] - t0 : -1, COLS + 3);
      end
      n_checks++;
      if (ovr_at == 0 ? (ovr_q.size() != 0)
                      : (ovr_q.size() != 1 || ovr_q[0] != t0 + ovr_at + 1)) begin
         n_fail++;
         $display("FAIL fetch_overrun: got count=%0d first=%0d expected cyc=%0d",
                  ovr_q.size(), (ovr_q.size() > 0) ? ovr_q[0] - t0 : -1, ovr_at == 0 ? -1 : ovr_at + 1);
      end
      n_checks++;
      if (wr_q.size() != 0) begin
         n_fail++;
         $display("FAIL fetch_no_write: got %0d writes expected 0", wr_q.size());
      end
   endtask

   task automatic test_bad_row();
      int t0, row;
      row = int'($urandom_range(ROWS, 31));
      clear_logs();
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b1;
      bus.i_fetch_row = 5'(row);
      t0 = cyc;
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b0;
      repeat (6) @(posedge clk);
      #1;
      n_checks++;
      if (rd_q.size() != 0 || lb_q.size() != 0) begin
         n_fail++;
         $display("FAIL bad_row_access row=%0d: got reads=%0d lb=%0d expected 0 0", row, rd_q.size(), lb_q.size());
      end
      n_checks++;
      if (done_q.size() != 1 || done_q[0] != t0 + 1) begin
         n_fail++;
         $display("FAIL bad_row_done: got count=%0d expected one pulse at cycle 1", done_q.size());
      end
   endtask

   task automatic test_contention();
      int t0, a, d, acc, exp_acc;
      logic exp_rdy;
      a = int'($urandom_range(0, CELLS - 1));
      d = int'($urandom_range(0, 255));
      acc = -1;
`ifdef VGA_VRAM_WR_SKID_EN
      exp_acc = 1;
`else
      exp_acc = COLS + 4;
`endif
      clear_logs();
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b1;
      bus.i_fetch_row = 5'($urandom_range(0, ROWS - 1));
      bus.i_wr_valid  = 1'b1;
      bus.i_wr_addr   = ADDR_W'(a);
      bus.i_wr_data   = DATA_W'(d);
      t0 = cyc;
      for (int c = 0; c < 34; c++) begin
         @(negedge clk);
`ifdef VGA_VRAM_WR_SKID_EN
         exp_rdy = (c == 1) || (c >= COLS + 5);
`else
         exp_rdy = (c >= COLS + 4);
`endif
         n_checks++;
         if (bus.o_wr_ready !== exp_rdy) begin
            n_fail++;
            $display("FAIL contention_ready c=%0d: got %b expected %b", c, bus.o_wr_ready, exp_rdy);
         end
         if (bus.i_wr_valid && bus.o_wr_ready) acc = c;
         @(posedge clk); #1;
         bus.i_fetch_req = 1'b0;
         if (acc == c) bus.i_wr_valid = 1'b0;
      end
      bus.i_wr_valid = 1'b0;
      n_checks++;
      if (acc != exp_acc) begin
         n_fail++;
         $display("FAIL contention_accept: got cycle %0d expected %0d", acc, exp_acc);
      end
      n_checks++;
      if (wr_q.size() != 1 || wr_q[0].c != t0 + COLS + 5 || wr_q[0].a != a || wr_q[0].d != d) begin
         n_fail++;
         $display("FAIL contention_write: got count=%0d cyc=%0d expected cyc=%0d addr=%0d data=%0d",
                  wr_q.size(), (wr_q.size() > 0) ? wr_q[0].c - t0 : -1, COLS + 5, a, d);
      end
      n_checks++;
      if (lb_q.size() != COLS || done_q.size() != 1 || done_q[0] != t0 + COLS + 3) begin
         n_fail++;
         $display("FAIL contention_fetch: got lb=%0d done=%0d expected lb=%0d done=1",
                  lb_q.size(), done_q.size(), COLS);
      end
      model_mem[a] = 8'(d);
   endtask

   task automatic test_reset_midfetch();
      logic [36:0] outs;
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b1;
      bus.i_fetch_row = 5'($urandom_range(0, ROWS - 1));
      @(posedge clk); #1;
      bus.i_fetch_req = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      outs = {bus.o_wr_ready, bus.o_wr_err, bus.o_ram_en, bus.o_ram_we, bus.o_ram_addr,
              bus.o_ram_wdata, bus.o_lb_we, bus.o_lb_addr, bus.o_lb_data,
              bus.o_fetch_done, bus.o_overrun};
      n_checks++;
      if (outs !== '0) begin
         n_fail++;
         $display("FAIL midfetch_reset_outputs: got %h expected 0", outs);
      end
      clear_logs();
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      n_checks++;
      if (done_q.size() != 0 || lb_q.size() != 0 || rd_q.size() != 0) begin
         n_fail++;
         $display("FAIL midfetch_abandon: got done=%0d lb=%0d reads=%0d expected 0 0 0",
                  done_q.size(), lb_q.size(), rd_q.size());
      end
   endtask

   initial begin
      for (int i = 0; i < 512; i++) begin
         mem[i]       = 8'(i);
         model_mem[i] = 8'(i);
      end
      bus.i_fetch_req = 1'b0;
      bus.i_fetch_row = '0;
      bus.i_wr_valid  = 1'b0;
      bus.i_wr_addr   = '0;
      bus.i_wr_data   = '0;
      bus.i_ram_rdata = '0;

      test_reset();
      test_fetch(3, 0);
      test_write(12);
      for (int i = 0; i < 3; i++) test_fetch(int'($urandom_range(0, ROWS - 1)), 0);
      test_contention();
      test_fetch(int'($urandom_range(0, ROWS - 1)), 10);
      test_bad_row();
      test_fetch(ROWS - 1, 0);
      test_write(6);
      test_reset_midfetch();
      test_fetch(0, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/vga_vram_arbiter.md
Name: vga_vram_arbiter

Overview:
- Shares one single-port character/cell RAM between two masters: the scan-out fetch engine and a host write port.
- During horizontal blank the fetch engine copies one row of cells into the display line buffer. The downscaled glyph datapath reads that line buffer during the visible area.
- Fetch has absolute priority because it has a hard deadline. Host writes use the remaining RAM cycles.

Parameters:
- COLS, 25, cells per text row (800 px / 32 px per cell).
- ROWS, 18, text rows per frame.
- ADDR_W, 9, RAM address width. COLS*ROWS must be ≤ 2^ADDR_W.
- DATA_W, 8, cell width in bits.
- LB_AW, 5, line-buffer address width. COLS must be ≤ 2^LB_AW.

Ports:
- i_clk  in  1  pixel clock (40 MHz domain).
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_fetch_req  in  1  one-cycle pulse from the timing generator at hblank start.
- i_fetch_row  in  5  text row to fetch; sampled with i_fetch_req.
- i_wr_valid  in  1  host write request.
- o_wr_ready  out  1  host write accepted when i_wr_valid & o_wr_ready.
- i_wr_addr  in  ADDR_W  host cell address.
- i_wr_data  in  DATA_W  host cell data.
- o_wr_err  out  1  one-cycle pulse: an accepted write had an out-of-range address.
- o_ram_en, o_ram_we  out  1  RAM strobe and write enable (registered).
- o_ram_addr  out  ADDR_W  RAM address (registered).
- o_ram_wdata  out  DATA_W  RAM write data (registered).
- i_ram_rdata  in  DATA_W  RAM read data, valid the cycle after a read strobe.
- o_lb_we  out  1  line-buffer write enable.
- o_lb_addr  out  LB_AW  line-buffer address.
- o_lb_data  out  DATA_W  line-buffer data.
- o_fetch_done  out  1  one-cycle pulse: row copy complete.
- o_overrun  out  1  one-cycle pulse: i_fetch_req arrived while not IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State is IDLE.
  - Every registered output is 0.
  - o_wr_ready is low while i_rst_n is low.
  - An in-flight fetch is abandoned and o_fetch_done is not pulsed.
- States: IDLE, FETCH, DRAIN, DONE.
- IDLE:
  - o_wr_ready = ~i_fetch_req (combinational).
  - When a write is accepted in cycle t, the RAM write appears during cycle t+1: o_ram_en=1, o_ram_we=1, o_ram_addr=i_wr_addr, o_ram_wdata=i_wr_data.
  - If i_wr_addr ≥ COLS*ROWS, the write is accepted but not performed (o_ram_en stays 0) and o_wr_err pulses in cycle t+1.
  - If i_fetch_req and i_wr_valid occur together, the fetch wins and the write is held off.
- FETCH entry:
  - On i_fetch_req in IDLE at cycle 0, latch base = i_fetch_row*COLS and enter FETCH.
  - If i_fetch_row ≥ ROWS, make no RAM access, go directly to DONE, and pulse o_fetch_done in cycle 1.
- FETCH:
  - Runs cycles 1..COLS: o_ram_en=1, o_ram_we=0, o_ram_addr=base+k for k=0..COLS-1.
  - An internal column counter counts 0..COLS-1.
- Read pipeline:
  - For a read strobed in cycle c, rdata is valid in c+1 and is registered to the line buffer in c+2.
  - o_lb_we=1, o_lb_addr=k, o_lb_data=cell during cycles 3..COLS+2.
- DRAIN: 2 cycles after the last read, until the last line-buffer write issues.
- DONE: o_fetch_done=1 in cycle COLS+3, then return to IDLE.
- o_wr_ready=0 throughout FETCH, DRAIN and DONE (macro off).
- An i_fetch_req while not IDLE is dropped and o_overrun pulses the next cycle. The current fetch is unaffected.
- Address arithmetic is unsigned. base+k never exceeds COLS*ROWS-1, so there is no wrap.
- Host-side rule: once i_wr_valid is high, i_wr_addr and i_wr_data stay stable until the transfer completes.

Optional Feature:
- Macro: VGA_VRAM_WR_SKID_EN.
- When defined:
  - Adds a one-entry write skid register.
  - Outside IDLE, o_wr_ready = skid empty. An accepted write is parked in the skid register.
  - On the first IDLE cycle, a parked write is issued to RAM before any new host write. o_wr_ready=0 during that cycle.
  - Range checking and o_wr_err are evaluated when the parked write issues.
- When undefined: behaviour is exactly as above, with no skid logic.

Test Plan:
- Reset, then write (addr 0x012, data 0xA5) in IDLE → next cycle o_ram_en=1, we=1, addr=0x012, wdata=0xA5; o_wr_err=0.
- i_fetch_req with row 3, RAM model returns addr[7:0] → reads 75..99 in cycles 1..25; o_lb_we in cycles 3..27 with o_lb_addr 0..24 and data 75..99; o_fetch_done in cycle 28 only.
- i_wr_valid held high plus i_fetch_req in the same cycle → o_wr_ready=0 cycles 0..28; write lands on RAM in cycle 30 (skid off).
- Second i_fetch_req at cycle 10 of a fetch → o_overrun pulses in cycle 11; exactly 25 line-buffer writes still occur.
- Write to addr 450 → accepted, no RAM strobe, o_wr_err=1 for one cycle. Fetch row 18 → no RAM strobe, o_fetch_done in cycle 1.
- Drop i_rst_n in cycle 12 of a fetch → all outputs 0 immediately, no o_fetch_done. With VGA_VRAM_WR_SKID_EN defined, a write offered during a fetch is accepted, then issued on the first IDLE cycle.
